// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
//   Turns the raw UART receive byte stream into the 9-bit tagged command
//   stream for the UART-to-APB bridge. The block hunts for SYNC_BYTE and
//   validates the header. It buffers the complete frame and then emits it as
//   one unbroken burst. Header words are {1'b0, H} and data words are {D, 1'b1}.
//   Malformed and timed-out frames are dropped and counted. With the checksum
//   option, frames that fail the checksum are dropped and counted as well.
//
// Optional feature macro: UART_CMD_FRAMER_CHECKSUM_EN
//   defined   : a checksum byte (XOR of H and the payload) follows the
//               payload. It is checked in the CHECK state and never forwarded.
//   undefined : no checksum byte; PAYLOAD goes straight to EMIT.
//
// Parameters
//   TIMEOUT_CYCLES  max idle cycles between bytes of one frame (0 = off)
//   SYNC_BYTE       frame start marker
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   s_axis_*         byte input (tready low only while emitting)
//   m_axis_*         tagged 9-bit output, tlast on final word, tuser = 0
//   busy             high whenever not hunting for SYNC
//   frame_count      frames fully emitted (wraps)
//   drop_count       frames discarded (wraps)
module uart_cmd_framer #(
   parameter int unsigned TIMEOUT_CYCLES = 125000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [8:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        busy,
   output logic [31:0] frame_count,
   output logic [31:0] drop_count
);

`ifdef UART_CMD_FRAMER_CHECKSUM_EN
   typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, CHECK, EMIT} state_t;
`else
   typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, EMIT} state_t;
`endif

   state_t      state;
   state_t      state_nxt;

   // Entry 0 holds the tagged header; entries 1..pay_len hold tagged payload.
   logic [8:0]  frame_buf [0:6];
   logic [2:0]  pay_len;
   logic [2:0]  wr_ptr;
   logic [2:0]  rd_ptr;
   logic [31:0] to_cnt;
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   logic        in_fire;
   logic        out_fire;
   logic        is_sync;
   logic [2:0]  hdr_op;
   logic        hdr_ok;
   logic        waiting;
   logic        timeout_hit;
   logic        drop_evt;
   logic        frame_evt;

   assign in_fire     = s_axis_tvalid && s_axis_tready;
   assign out_fire    = m_axis_tvalid && m_axis_tready;
   assign is_sync     = (s_axis_tdata == SYNC_BYTE);
   assign hdr_op      = s_axis_tdata[3:1];
   assign hdr_ok      = !s_axis_tdata[0] && ((hdr_op == 3'd1) || (hdr_op == 3'd2));
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
   assign waiting     = (state == HEADER) || (state == PAYLOAD) || (state == CHECK);
`else
   assign waiting     = (state == HEADER) || (state == PAYLOAD);
`endif
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TIMEOUT_CYCLES);

   always_ff @(posedge clk) begin
      if (rst) state <= HUNT;
      else     state <= state_nxt;
   end

   // An accepted byte always takes priority over a timeout in the same cycle.
   always_comb begin
      state_nxt = state;
      drop_evt  = 1'b0;
      frame_evt = 1'b0;
      case (state)
         HUNT: begin
            if (in_fire && is_sync) state_nxt = HEADER;
         end
         HEADER: begin
            if (in_fire) begin
               if (!is_sync) begin
                  if (hdr_ok) begin
                     state_nxt = PAYLOAD;
                  end else begin
                     drop_evt  = 1'b1;
                     state_nxt = HUNT;
                  end
               end
            end else if (timeout_hit) begin
               drop_evt  = 1'b1;
               state_nxt = HUNT;
            end
         end
         PAYLOAD: begin
            if (in_fire) begin
               if (wr_ptr == pay_len) begin
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
                  state_nxt = CHECK;
`else
                  state_nxt = EMIT;
`endif
               end
            end else if (timeout_hit) begin
               drop_evt  = 1'b1;
               state_nxt = HUNT;
            end
         end
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
         CHECK: begin
            if (in_fire) begin
               if (s_axis_tdata == csum) begin
                  state_nxt = EMIT;
               end else begin
                  drop_evt  = 1'b1;
                  state_nxt = HUNT;
               end
            end else if (timeout_hit) begin
               drop_evt  = 1'b1;
               state_nxt = HUNT;
            end
         end
`endif
         EMIT: begin
            if (out_fire && m_axis_tlast) begin
               frame_evt = 1'b1;
               state_nxt = HUNT;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_buf   <= '{default: '0};
         pay_len     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         to_cnt      <= '0;
         frame_count <= '0;
         drop_count  <= '0;
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         if (drop_evt)  drop_count  <= drop_count + 32'd1;
         if (frame_evt) frame_count <= frame_count + 32'd1;

         // Idle counter: runs only while waiting inside a frame with no byte.
         if (waiting && !in_fire && (state_nxt == state)) to_cnt <= to_cnt + 32'd1;
         else                                             to_cnt <= '0;

         if ((state == HEADER) && in_fire && !is_sync && hdr_ok) begin
            frame_buf[0] <= {1'b0, s_axis_tdata};
            pay_len      <= (hdr_op == 3'd1) ? 3'd6 : 3'd2;
            wr_ptr       <= 3'd1;
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
            csum         <= s_axis_tdata;
`endif
         end

         if ((state == PAYLOAD) && in_fire) begin
            frame_buf[wr_ptr] <= {s_axis_tdata, 1'b1};
            wr_ptr            <= wr_ptr + 3'd1;
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
            csum              <= csum ^ s_axis_tdata;
`endif
         end

         if (state != EMIT)  rd_ptr <= '0;
         else if (out_fire)  rd_ptr <= rd_ptr + 3'd1;
      end
   end

   // Outputs decode straight from registers, so they hold while stalled.
   assign s_axis_tready = (state != EMIT);
   assign busy          = (state != HUNT);
   assign m_axis_tvalid = (state == EMIT);
   assign m_axis_tdata  = m_axis_tvalid ? frame_buf[rd_ptr] : '0;
   assign m_axis_tlast  = m_axis_tvalid && (rd_ptr == pay_len);
   assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_uart_cmd_framer.sv
`timescale 1ns/1ps
module tb_uart_cmd_framer;
   localparam int unsigned TMO  = 16;
   localparam logic [7:0]  SYNC = 8'hA5;
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [8:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        busy;
   logic [31:0] frame_count;
   logic [31:0] drop_count;

   uart_cmd_framer #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(SYNC)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .busy(busy), .frame_count(frame_count), .drop_count(drop_count)
   );

   always #4 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed output handshakes and model expectations
   logic [8:0]  out_q[$];
   logic        out_l_q[$];
   int unsigned out_c_q[$];
   logic [8:0]  exp_q[$];
   logic        exp_l_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  pl [0:5];
   int unsigned exp_frames = 0;
   int unsigned exp_drops  = 0;
   int unsigned last_acc_cyc = 0;
   int          gap_max  = 0;
   int          rdy_mode = 0;
   int unsigned rdy_step = 0;
   int          stall_viol = 0;
   int          notready_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [8:0]  prev_data = '0;
   logic        prev_last = 1'b0;

   // Output ready driver: 0 always ready, 1 random, 2 pattern 1,0,0,1, else held low
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            2: begin
               m_axis_tready = ((rdy_step % 4) == 0) || ((rdy_step % 4) == 3);
               rdy_step++;
            end
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Monitor sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
            stall_viol++;
         if (!s_axis_tready) notready_cnt++;
         if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back(m_axis_tdata);
            out_l_q.push_back(m_axis_tlast);
            out_c_q.push_back(cyc + 1);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_q();
      out_q.delete(); out_l_q.delete(); out_c_q.delete();
      exp_q.delete(); exp_l_q.delete(); tx_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         n_checks++; n_fail++;
         $display("FAIL send_wait: s_axis_tready got 0 for 500 cycles, want 1");
      end
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      last_acc_cyc  = cyc;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_all();
      while (tx_q.size() > 0) begin
         send_byte(tx_q.pop_front());
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
      end
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      @(negedge clk);
      while ((busy || out_q.size() < exp_q.size()) && n < 2000) begin @(negedge clk); n++; end
      n_checks++;
      if (n >= 2000) begin
         n_fail++;
         $display("FAIL wait_done: busy=%0b words=%0d, want busy=0 words=%0d", busy, out_q.size(), exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // Reference frame: SYNC, H, payload, optional XOR checksum; expected words follow the tag rule.
   task automatic build_frame(input logic [7:0] h, input int n, input bit good, input bit resync);
      logic [7:0] x;
      bit emit;
      x = h;
      emit = good || !CSUM_EN;
      if (resync) tx_q.push_back(SYNC);
      tx_q.push_back(SYNC);
      tx_q.push_back(h);
      if (emit) begin exp_q.push_back({1'b0, h}); exp_l_q.push_back(1'b0); end
      for (int i = 0; i < n; i++) begin
         tx_q.push_back(pl[i]);
         x ^= pl[i];
         if (emit) begin exp_q.push_back({pl[i], 1'b1}); exp_l_q.push_back(i == n - 1); end
      end
      if (CSUM_EN) tx_q.push_back(good ? x : (x ^ 8'h01));
      if (emit) exp_frames++;
      else      exp_drops++;
   endtask

   function automatic int first_diff();
      if (out_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i]) if (out_q[i] !== exp_q[i] || out_l_q[i] !== exp_l_q[i]) return i;
      return -1;
   endfunction

   task automatic test_reset();
      do_reset();
      n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_s_tready: got %b want 1", s_axis_tready); end
      n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid); end
      n_checks++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_m_tlast: got %b want 0", m_axis_tlast); end
      n_checks++; if (m_axis_tdata !== 9'h000) begin n_fail++; $display("FAIL rst_m_tdata: got %h want 000", m_axis_tdata); end
      n_checks++; if (m_axis_tuser !== 1'b0) begin n_fail++; $display("FAIL rst_m_tuser: got %b want 0", m_axis_tuser); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
      n_checks++; if (drop_count !== 32'd0) begin n_fail++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
   endtask

   task automatic test_write_frame();
      logic [8:0] want [0:6];
      want = '{9'h012, 9'h069, 9'h025, 9'h1DF, 9'h17D, 9'h15B, 9'h1BD};
      clear_q(); rdy_mode = 0; gap_max = 0;
      tx_q = '{8'hA5, 8'h12, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      if (CSUM_EN) tx_q.push_back(8'h16);
      for (int i = 0; i < 7; i++) begin exp_q.push_back(want[i]); exp_l_q.push_back(i == 6); end
      exp_frames++;
      send_all();
      wait_done();
      n_checks++;
      if (out_q.size() != 7) begin
         n_fail++; $display("FAIL write_len: got %0d words want 7", out_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (out_q[i] !== want[i] || out_l_q[i] !== (i == 6)) begin
               n_fail++;
               $display("FAIL write_word[%0d]: got %h last=%b want %h last=%b", i, out_q[i], out_l_q[i], want[i], (i == 6));
            end
            n_checks++;
            if (out_c_q[i] !== last_acc_cyc + 1 + i) begin
               n_fail++;
               $display("FAIL write_cycle[%0d]: got cycle %0d want %0d", i, out_c_q[i], last_acc_cyc + 1 + i);
            end
         end
      end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL write_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

   task automatic test_read_frame();
      int nr0;
      clear_q(); rdy_mode = 0; gap_max = 0;
      tx_q = '{8'hA5, 8'h04, 8'h00, 8'h10};
      if (CSUM_EN) tx_q.push_back(8'h14);
      exp_q = '{9'h004, 9'h001, 9'h021};
      exp_l_q = '{1'b0, 1'b0, 1'b1};
      exp_frames++;
      nr0 = notready_cnt;
      send_all();
      wait_done();
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL read_words: got %0d words (diff at %0d) want 004 001 021", out_q.size(), first_diff()); end
      n_checks++; if (notready_cnt - nr0 != 3) begin n_fail++; $display("FAIL read_tready_low: got %0d cycles want 3", notready_cnt - nr0); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL read_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

   task automatic test_bad_header();
      clear_q(); rdy_mode = 0; gap_max = 0;
      tx_q = '{8'hA5, 8'h0E};
      exp_drops++;
      pl[0] = 8'h00; pl[1] = 8'h10;
      build_frame(8'h04, 2, 1'b1, 1'b0);
      build_frame(8'h04, 2, 1'b1, 1'b1);
      send_all();
      wait_done();
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL badhdr_words: got %0d words (diff at %0d) want %0d", out_q.size(), first_diff(), exp_q.size()); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL badhdr_drop_count: got %0d want %0d", drop_count, exp_drops); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL badhdr_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

   task automatic test_timeout();
      clear_q(); rdy_mode = 0; gap_max = 0;
      send_byte(SYNC); send_byte(8'h12); send_byte(8'h34);
      repeat (TMO) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: busy got %b want 1", busy); end
      @(posedge clk); #1;
      exp_drops++;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL timeout_drop_count: got %0d want %0d", drop_count, exp_drops); end
      n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL timeout_output: got %0d words want 0", out_q.size()); end
      // A byte landing on the expiry cycle keeps the frame alive
      pl = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      build_frame(8'h12, 6, 1'b1, 1'b0);
      repeat (3) send_byte(tx_q.pop_front());
      repeat (TMO) @(posedge clk);
      send_all();
      wait_done();
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL timeout_edge_words: got %0d words (diff at %0d) want %0d", out_q.size(), first_diff(), exp_q.size()); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL timeout_edge_drop_count: got %0d want %0d", drop_count, exp_drops); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL timeout_edge_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

   task automatic test_stall();
      int sv0;
      int lasts;
      clear_q(); gap_max = 0;
      rdy_step = 0; rdy_mode = 2;
      for (int i = 0; i < 6; i++) pl[i] = 8'($urandom);
      build_frame({4'($urandom), 3'd1, 1'b0}, 6, 1'b1, 1'b0);
      sv0 = stall_viol;
      send_all();
      wait_done();
      rdy_mode = 0;
      lasts = 0;
      foreach (out_l_q[i]) if (out_l_q[i]) lasts++;
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL stall_words: got %0d words (diff at %0d) want %0d", out_q.size(), first_diff(), exp_q.size()); end
      n_checks++; if (stall_viol != sv0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_viol - sv0); end
      n_checks++; if (lasts != 1) begin n_fail++; $display("FAIL stall_tlast: got %0d tlast beats want 1", lasts); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL stall_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

`ifdef UART_CMD_FRAMER_CHECKSUM_EN
   task automatic test_checksum();
      clear_q(); rdy_mode = 0; gap_max = 0;
      tx_q = '{8'hA5, 8'h12, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h16};
      exp_q = '{9'h012, 9'h069, 9'h025, 9'h1DF, 9'h17D, 9'h15B, 9'h1BD};
      exp_l_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      exp_frames++;
      tx_q.push_back(8'hA5); tx_q.push_back(8'h04); tx_q.push_back(8'h00);
      tx_q.push_back(8'h10); tx_q.push_back(8'h15);
      exp_drops++;
      send_all();
      wait_done();
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL csum_words: got %0d words (diff at %0d) want 7", out_q.size(), first_diff()); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL csum_drop_count: got %0d want %0d", drop_count, exp_drops); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL csum_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask
`endif

   task automatic test_random();
      int sv0;
      logic [7:0] b;
      logic [7:0] h;
      clear_q(); rdy_mode = 1; gap_max = 3;
      for (int s = 0; s < 40; s++) begin
         int unsigned kind;
         kind = $urandom_range(0, 9);
         if (kind <= 1) begin
            repeat ($urandom_range(1, 3)) begin
               b = 8'($urandom);
               if (b == SYNC) b = 8'h00;
               tx_q.push_back(b);
            end
         end else if (kind == 2) begin
            do h = 8'($urandom); while (h == SYNC || (!h[0] && (h[3:1] == 3'd1 || h[3:1] == 3'd2)));
            tx_q.push_back(SYNC);
            tx_q.push_back(h);
            exp_drops++;
         end else begin
            h = {4'($urandom), ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2, 1'b0};
            for (int i = 0; i < 6; i++) pl[i] = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
            build_frame(h, (h[3:1] == 3'd1) ? 6 : 2, kind != 3, kind == 4);
         end
      end
      sv0 = stall_viol;
      send_all();
      wait_done();
      rdy_mode = 0; gap_max = 0;
      n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL random_words: got %0d words (diff at %0d) want %0d", out_q.size(), first_diff(), exp_q.size()); end
      n_checks++; if (stall_viol != sv0) begin n_fail++; $display("FAIL random_hold: got %0d unstable stalls want 0", stall_viol - sv0); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL random_drop_count: got %0d want %0d", drop_count, exp_drops); end
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL random_frame_count: got %0d want %0d", frame_count, exp_frames); end
   endtask

   task automatic test_reset_mid_emit();
      int unsigned n = 0;
      clear_q(); gap_max = 0; rdy_mode = 3;
      pl[0] = 8'h00; pl[1] = 8'h10;
      build_frame(8'h04, 2, 1'b1, 1'b0);
      send_all();
      while (!m_axis_tvalid && n < 50) begin @(negedge clk); n++; end
      n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstemit_enter: tvalid got %b want 1", m_axis_tvalid); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstemit_tvalid: got %b want 0", m_axis_tvalid); end
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 0;
      exp_frames = 0; exp_drops = 0;
      repeat (4) @(negedge clk);
      n_checks++; if (frame_count !== exp_frames) begin n_fail++; $display("FAIL rstemit_frame_count: got %0d want 0", frame_count); end
      n_checks++; if (drop_count !== exp_drops) begin n_fail++; $display("FAIL rstemit_drop_count: got %0d want 0", drop_count); end
      n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL rstemit_output: got %0d words want 0", out_q.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstemit_busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_write_frame();
      test_read_frame();
      test_bad_header();
      test_timeout();
      test_stall();
`ifdef UART_CMD_FRAMER_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      test_reset_mid_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
